mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  Y86-64 memory stage plus the W pipeline register. Consumes the M-register outputs
//  (M_stat..M_dstM), performs the data-memory read/write, forms m_stat/m_valM, and
//  registers the write-back bundle (W_*). Tracks a sticky halt once a non-AOK status retires.
// PARAMETERS
//  MEM_BYTES  4096  data-memory size in bytes (byte-addressed, little-endian quadwords)
// PORTS
//  clk       in   1   clock; all state updates on posedge
//  rst       in   1   synchronous, active-high reset
//  M_stat    in   3   status from M register (AOK=1,HLT=2,ADR=3,INS=4)
//  M_icode   in   4   instruction code from M register
//  M_Cnd     in   1   condition flag (passed to nothing; kept for cmov visibility in W_icode path)
//  M_valE    in   64  ALU result / memory address
//  M_valA    in   64  store data, or address for popq/ret
//  M_dstE    in   4   destination for valE (0xF = none)
//  M_dstM    in   4   destination for valM (0xF = none)
//  W_stall   in   1   hold W register contents
//  W_bubble  in   1   load NOP bubble into W register
//  ld_en     in   1   bench/loader byte write into data memory
//  ld_addr   in   64  loader byte address
//  ld_byte   in   8   loader byte data
//  m_valM    out  64  combinational read data (0 when no read or address error)
//  m_stat    out  3   combinational stage status
//  W_stat/W_icode/W_valE/W_valM/W_dstE/W_dstM  out  3/4/64/64/4/4  write-back bundle
//  halted    out  1   sticky: a non-AOK status has been loaded into W
// BEHAVIOUR
//  - Memory address: M_valE for rmmovq(4), mrmovq(5), pushq(A), call(8); M_valA for popq(B), ret(9).
//  - Read for 5,B,9; write for 4,A,8 with data M_valA. Other icodes: no access.
//  - Address error: access and addr+8 > MEM_BYTES, computed in 65 bits (no wrap; 0xFFFF_FFFF_FFFF_FFF9 errs).
//  - m_stat = ADR if address error, else M_stat. m_valM = 8 bytes at addr, LE, same cycle.
//  - Write commits at posedge only if write && !adr_err && M_stat==AOK && !halted && !rst
//    && !W_stall; 8 bytes LE. Read-during-write to same address returns old data.
//  - ld_en writes one byte at posedge if ld_addr<MEM_BYTES; out-of-range ignored; pipeline
//    write to same byte in same cycle wins.
//  - W register, priority rst > W_bubble > halted-hold > W_stall > load:
//    rst/bubble: W_stat=AOK, W_icode=1(NOP), W_valE=0, W_valM=0, W_dstE=W_dstM=0xF.
//    load: W_stat=m_stat, W_icode=M_icode, W_valE=M_valE, W_valM=m_valM, W_dstE=M_dstE, W_dstM=M_dstM.
//  - halted: rst->0; set at posedge when a load places W_stat!=AOK; then W frozen and
//    writes blocked until rst. Bubble while halted still clears W but not halted.
//  - Reset: all outputs above to bubble values, halted=0, memory cleared to 0. Reset mid-
//    store: no write commits in the reset cycle. Latency: M inputs -> W outputs 1 cycle.
// STRUCTURE
//  - y86_pkg: icode constants (NOP,RMMOVQ,MRMOVQ,CALL,RET,PUSHQ,POPQ), stat codes
//    (AOK,HLT,ADR,INS), RNONE=4'hF.
//  - Sub-module data_mem: byte array, 8-byte LE combinational read port, gated 8-byte
//    write port, loader byte port, sync clear. Stage logic + W register in top.
// TESTING
//  - Loader writes 0x1122334455667788 LE at 0x100; mrmovq valE=0x100 -> m_valM and next W_valM = 0x1122334455667788.
//  - rmmovq valE=0x200 valA=0xDEADBEEF; next cycle mrmovq 0x200 -> W_valM=0xDEADBEEF.
//  - mrmovq valE=MEM_BYTES-7 (4089) -> m_stat=ADR, m_valM=0, W_stat=3, halted=1; later stores ignored.
//  - pushq valE=0xFFFF_FFFF_FFFF_FFF9 -> ADR, no memory change; popq valA=0x0 reads addr 0.
//  - rmmovq with W_stall=1 -> W unchanged, no write; W_bubble=1 -> W_icode=1, dstE=dstM=0xF.
//  - rst asserted same cycle as rmmovq 0x300 -> mem[0x300..0x307]=0, halted=0, W = bubble.

Source files
------------

// File: rtl/y86_pkg.sv
// y86_pkg: icode and status constants shared by the memory/write-back stage
package y86_pkg;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [2:0] S_AOK    = 3'd1;
  localparam logic [2:0] S_HLT    = 3'd2;
  localparam logic [2:0] S_ADR    = 3'd3;
  localparam logic [2:0] S_INS    = 3'd4;
  localparam logic [3:0] RNONE    = 4'hF;
endpackage

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: M-register inputs, pipeline controls, loader port, m_* results and W bundle
interface mem_wb_stage_if;
  logic [2:0]  M_stat;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;
  logic        W_stall;
  logic        W_bubble;
  logic        ld_en;
  logic [63:0] ld_addr;
  logic [7:0]  ld_byte;
  logic [63:0] m_valM;
  logic [2:0]  m_stat;
  logic [2:0]  W_stat;
  logic [3:0]  W_icode;
  logic [63:0] W_valE;
  logic [63:0] W_valM;
  logic [3:0]  W_dstE;
  logic [3:0]  W_dstM;
  logic        halted;
  modport master (output M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM, W_stall, W_bubble,
                  ld_en, ld_addr, ld_byte,
                  input m_valM, m_stat, W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM, halted);
  modport slave (input M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM, W_stall, W_bubble,
                 ld_en, ld_addr, ld_byte,
                 output m_valM, m_stat, W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM, halted);
endinterface

// File: rtl/mem_wb_stage_data_mem.sv
// data_mem: byte array with 8-byte LE combinational read, gated 8-byte write, loader byte port, sync clear
// ports: clk, rst, addr/rdata (read+write address, read data), we/wdata, ld_en/ld_addr/ld_byte
module data_mem #(
  parameter int MEM_BYTES = 4096,
  localparam int AW = $clog2(MEM_BYTES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  output logic [63:0]   rdata,
  input  logic          we,
  input  logic [63:0]   wdata,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_byte
);
  logic [7:0] mem [MEM_BYTES];
  // index wrap past the top is harmless: the stage masks reads and writes on address error
  always_comb begin
    rdata = '0;
    for (int i = 0; i < 8; i++) rdata[8*i +: 8] = mem[addr + AW'(i)];
  end
  // the pipeline write is issued after the loader so it wins on a shared byte
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_BYTES; i++) mem[i] <= '0;
    end else begin
      if (ld_en) mem[ld_addr] <= ld_byte;
      if (we) for (int i = 0; i < 8; i++) mem[addr + AW'(i)] <= wdata[8*i +: 8];
    end
  end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: Y86-64 memory stage and W pipeline register with sticky halt
// ports: clk, rst (sync, active-high), bus (slave view of mem_wb_stage_if)
module mem_wb_stage
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 4096
) (
  input logic            clk,
  input logic            rst,
  mem_wb_stage_if.slave  bus
);
  localparam int AW = $clog2(MEM_BYTES);
  logic        rd, wr, adr_err, we, ld_ok, unused_cnd;
  logic [63:0] addr, rdata;
  assign unused_cnd = bus.M_Cnd;
  always_comb begin
    rd = bus.M_icode inside {I_MRMOVQ, I_POPQ, I_RET};
    wr = bus.M_icode inside {I_RMMOVQ, I_PUSHQ, I_CALL};
    addr = (bus.M_icode inside {I_POPQ, I_RET}) ? bus.M_valA : bus.M_valE;
    // 65-bit sum so addresses near 2^64 cannot wrap into range
    adr_err = (rd || wr) && ({1'b0, addr} + 65'd8 > 65'(MEM_BYTES));
    we = wr && !adr_err && bus.M_stat == S_AOK && !bus.halted && !rst && !bus.W_stall;
    ld_ok = bus.ld_en && bus.ld_addr < 64'(MEM_BYTES);
  end
  assign bus.m_stat = adr_err ? S_ADR : bus.M_stat;
  assign bus.m_valM = (rd && !adr_err) ? rdata : '0;
  data_mem #(.MEM_BYTES(MEM_BYTES)) u_mem (
    .clk(clk), .rst(rst), .addr(addr[AW-1:0]), .rdata(rdata), .we(we), .wdata(bus.M_valA),
    .ld_en(ld_ok), .ld_addr(bus.ld_addr[AW-1:0]), .ld_byte(bus.ld_byte)
  );
  always_ff @(posedge clk) begin
    if (rst || bus.W_bubble) begin
      bus.W_stat  <= S_AOK;
      bus.W_icode <= I_NOP;
      bus.W_valE  <= '0;
      bus.W_valM  <= '0;
      bus.W_dstE  <= RNONE;
      bus.W_dstM  <= RNONE;
    end else if (!bus.halted && !bus.W_stall) begin
      bus.W_stat  <= bus.m_stat;
      bus.W_icode <= bus.M_icode;
      bus.W_valE  <= bus.M_valE;
      bus.W_valM  <= bus.m_valM;
      bus.W_dstE  <= bus.M_dstE;
      bus.W_dstM  <= bus.M_dstM;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) bus.halted <= 1'b0;
    else if (!bus.W_bubble && !bus.halted && !bus.W_stall && bus.m_stat != S_AOK) bus.halted <= 1'b1;
  end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: table vectors, hand sequences and random stimulus against a byte-array reference model
module tb_mem_wb_stage;
  localparam int MB = 4096;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  mem_wb_stage_if bus();
  mem_wb_stage #(.MEM_BYTES(MB)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0, n_bad = 0;
  logic [7:0]  mdl [MB];
  bit          mhalt;
  logic [2:0]  ew_stat;
  logic [3:0]  ew_icode, ew_dstE, ew_dstM;
  logic [63:0] ew_valE, ew_valM;

  typedef struct {
    logic [3:0] icode; logic [2:0] stat; logic [63:0] valE, valA; logic stall, bubble;
    logic [2:0] x_mstat; logic [63:0] x_mvalM;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rd8(logic [63:0] a);
    logic [63:0] v = 0;
    for (int i = 0; i < 8; i++) v |= 64'(mdl[int'(a) + i]) << (8 * i);
    return v;
  endfunction

  task automatic set_m(logic [3:0] ic, logic [2:0] st, logic [63:0] ve, logic [63:0] va, logic stall, logic bub);
    bus.M_icode = ic; bus.M_stat = st; bus.M_valE = ve; bus.M_valA = va;
    bus.W_stall = stall; bus.W_bubble = bub;
    bus.M_dstE = 4'($urandom); bus.M_dstM = 4'($urandom); bus.M_Cnd = 1'($urandom);
  endtask

  task automatic set_bubble_model();
    ew_stat = 1; ew_icode = 1; ew_valE = 0; ew_valM = 0; ew_dstE = 4'hF; ew_dstM = 4'hF;
  endtask

  task automatic check_w();
    chk("W_stat", 64'(bus.W_stat), 64'(ew_stat));
    chk("W_icode", 64'(bus.W_icode), 64'(ew_icode));
    chk("W_valE", bus.W_valE, ew_valE);
    chk("W_valM", bus.W_valM, ew_valM);
    chk("W_dstE", 64'(bus.W_dstE), 64'(ew_dstE));
    chk("W_dstM", 64'(bus.W_dstM), 64'(ew_dstM));
    chk("halted", 64'(bus.halted), 64'(mhalt));
  endtask

  // one clock: predict m_* from the model, check, then advance model and check W after the edge
  task automatic cycle();
    logic is_rd, is_wr, err;
    logic [63:0] a, evm;
    logic [2:0] est;
    is_rd = bus.M_icode == 5 || bus.M_icode == 11 || bus.M_icode == 9;
    is_wr = bus.M_icode == 4 || bus.M_icode == 10 || bus.M_icode == 8;
    a = (bus.M_icode == 11 || bus.M_icode == 9) ? bus.M_valA : bus.M_valE;
    err = (is_rd || is_wr) && a > 64'(MB - 8);
    est = err ? 3'd3 : bus.M_stat;
    evm = (is_rd && !err) ? rd8(a) : 64'd0;
    #2;
    chk("m_stat", 64'(bus.m_stat), 64'(est));
    chk("m_valM", bus.m_valM, evm);
    if (rst) begin
      for (int i = 0; i < MB; i++) mdl[i] = 0;
      mhalt = 0;
      set_bubble_model();
    end else begin
      if (bus.ld_en && bus.ld_addr < 64'(MB)) mdl[int'(bus.ld_addr)] = bus.ld_byte;
      if (is_wr && !err && bus.M_stat == 1 && !mhalt && !bus.W_stall)
        for (int i = 0; i < 8; i++) mdl[int'(a) + i] = bus.M_valA[8*i +: 8];
      if (bus.W_bubble) set_bubble_model();
      else if (!mhalt && !bus.W_stall) begin
        ew_stat = est; ew_icode = bus.M_icode; ew_valE = bus.M_valE; ew_valM = evm;
        ew_dstE = bus.M_dstE; ew_dstM = bus.M_dstM;
        if (est != 1) mhalt = 1;
      end
    end
    @(posedge clk); #1;
    check_w();
  endtask

  function automatic logic [63:0] rnd_addr();
    case ($urandom_range(0, 4))
      0: return 64'($urandom_range(MB - 16, MB + 8));
      1: return {$urandom, $urandom};
      default: return 64'($urandom_range(0, 63) * 8 + $urandom_range(0, 1) * 3);
    endcase
  endfunction

  initial begin
    tbl[0] = '{4'h5, 3'd1, 64'h100, 64'h0, 0, 0, 3'd1, 64'h1122334455667788};
    tbl[1] = '{4'h4, 3'd1, 64'h200, 64'hDEADBEEF, 0, 0, 3'd1, 64'h0};
    tbl[2] = '{4'h5, 3'd1, 64'h200, 64'h0, 0, 0, 3'd1, 64'hDEADBEEF};
    tbl[3] = '{4'hB, 3'd1, 64'h5555, 64'h0, 0, 0, 3'd1, 64'h0};
    tbl[4] = '{4'h5, 3'd1, 64'd4088, 64'h0, 0, 0, 3'd1, 64'h0};
    tbl[5] = '{4'h4, 3'd1, 64'h300, 64'h77, 1, 0, 3'd1, 64'h0};
    tbl[6] = '{4'h5, 3'd1, 64'h300, 64'h0, 0, 0, 3'd1, 64'h0};
    tbl[7] = '{4'h1, 3'd1, 64'h0, 64'h0, 0, 1, 3'd1, 64'h0};
    tbl[8] = '{4'hA, 3'd1, 64'hFFFF_FFFF_FFFF_FFF9, 64'h5, 0, 0, 3'd3, 64'h0};
    tbl[9] = '{4'h4, 3'd1, 64'h308, 64'h99, 0, 0, 3'd1, 64'h0};
    bus.ld_en = 0; bus.ld_addr = 0; bus.ld_byte = 0;
    set_m(4'h1, 3'd1, 0, 0, 0, 0);
    rst = 1;
    repeat (2) begin @(posedge clk); #1; end
    for (int i = 0; i < MB; i++) mdl[i] = 0;
    mhalt = 0;
    set_bubble_model();
    check_w();
    rst = 0;
    for (int i = 0; i < 8; i++) begin
      bus.ld_en = 1; bus.ld_addr = 64'h100 + 64'(i); bus.ld_byte = 8'h88 - 8'(i * 8'h11);
      cycle();
    end
    bus.ld_en = 0;
    for (int k = 0; k < 10; k++) begin
      set_m(tbl[k].icode, tbl[k].stat, tbl[k].valE, tbl[k].valA, tbl[k].stall, tbl[k].bubble);
      #1;
      chk($sformatf("tbl%0d_m_stat", k), 64'(bus.m_stat), 64'(tbl[k].x_mstat));
      chk($sformatf("tbl%0d_m_valM", k), bus.m_valM, tbl[k].x_mvalM);
      cycle();
      if (k == 7) chk("bubble_icode", 64'(bus.W_icode), 64'h1);
    end
    chk("halted_after_adr", 64'(bus.halted), 64'h1);
    set_m(4'h5, 3'd1, 64'h308, 0, 0, 0); cycle();
    chk("blocked_store", bus.m_valM, 64'h0);
    rst = 1;
    set_m(4'h4, 3'd1, 64'h300, 64'hAAAA_BBBB, 0, 0); cycle();
    rst = 0;
    chk("rst_halted", 64'(bus.halted), 64'h0);
    chk("rst_W_dstE", 64'(bus.W_dstE), 64'hF);
    set_m(4'h5, 3'd1, 64'h300, 0, 0, 0);
    #1 chk("rst_store_dropped", bus.m_valM, 64'h0);
    cycle();
    set_m(4'h5, 3'd1, 64'd4089, 0, 0, 0); cycle();
    chk("adr_W_stat", 64'(bus.W_stat), 64'h3);
    rst = 1; set_m(4'h1, 3'd1, 0, 0, 0, 0); cycle(); rst = 0;
    for (int n = 0; n < 1500; n++) begin
      rst = (mhalt && $urandom_range(0, 7) == 0) || $urandom_range(0, 199) == 0;
      set_m(4'($urandom_range(0, 11)), ($urandom_range(0, 9) == 0) ? 3'($urandom_range(2, 4)) : 3'd1,
            rnd_addr(), ($urandom_range(0, 1) == 0) ? rnd_addr() : {$urandom, $urandom},
            $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
      bus.ld_en = $urandom_range(0, 4) == 0;
      bus.ld_addr = 64'($urandom_range(0, MB + 4));
      bus.ld_byte = 8'($urandom);
      cycle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
